// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use, branch, memory waits, halt.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W        = 4,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned STAT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  imem_stall,
  input  logic                  dmem_stall,
  input  logic                  wb_halt,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  halted,
  output logic [STAT_W-1:0]     stall_cycles,
  output logic [STAT_W-1:0]     flush_count
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, HALT} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             load_use;

  // Register 0 never carries a real dependency.
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (wb_halt) begin
      halted <= 1'b1;
    end
  end

  // Priority-ordered hazard resolution; enables/flushes are combinational.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (state == HALT || wb_halt) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      next_state = HALT;
    end else if (dmem_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      next_state = MEM_WAIT;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      next_cnt   = '0;
      next_state = RUN;
    end else if (state == LOAD_STALL) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      if (cnt == '0) begin
        next_state = RUN;
      end else begin
        next_cnt = cnt - CNT_W'(1);
      end
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      // The first bubble is this cycle, so the counter holds the remaining extra ones.
      if (LOAD_STALL_CYCLES > 1) begin
        next_cnt   = CNT_W'(LOAD_STALL_CYCLES - 2);
        next_state = LOAD_STALL;
      end else begin
        next_state = RUN;
      end
    end else if (imem_stall) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
      next_state = RUN;
    end else begin
      next_state = RUN;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating stall and branch-flush event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (state != HALT) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STAT_W'(1);
      end
      if (ifid_flush && idex_flush && (flush_count != '1)) begin
        flush_count <= flush_count + STAT_W'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl; two instances (1 and 3 load bubbles)
// are checked every cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic       ex_branch_taken = 1'b0, imem_stall = 1'b0, dmem_stall = 1'b0, wb_halt = 1'b0;

  wire [7:0]  o1, o3;
  wire [15:0] sc1, fc1, sc3, fc3;

  int tests  = 0;
  int failed = 0;

  bit mh[2];
  int left[2];
  int sc[2];
  int fc[2];
  int nval[2] = '{1, 3};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(1), .STAT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .wb_halt(wb_halt), .pc_en(o1[7]), .ifid_en(o1[6]), .idex_en(o1[5]), .exmem_en(o1[4]),
    .memwb_en(o1[3]), .ifid_flush(o1[2]), .idex_flush(o1[1]), .halted(o1[0]),
    .stall_cycles(sc1), .flush_count(fc1));

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(3), .STAT_W(16)) dut3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .wb_halt(wb_halt), .pc_en(o3[7]), .ifid_en(o3[6]), .idex_en(o3[5]), .exmem_en(o3[4]),
    .memwb_en(o3[3]), .ifid_flush(o3[2]), .idex_flush(o3[1]), .halted(o3[0]),
    .stall_cycles(sc3), .flush_count(fc3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_stats(input int k, input string tag);
    logic [15:0] gs, gf;
    gs = (k == 0) ? sc1 : sc3;
    gf = (k == 0) ? fc1 : fc3;
`ifdef HAZARD_STATS_EN
    check_eq({tag, "_stall_cycles"}, 32'(gs), 32'(sc[k]));
    check_eq({tag, "_flush_count"}, 32'(gf), 32'(fc[k]));
`else
    check_eq({tag, "_stall_cycles"}, 32'(gs), 32'd0);
    check_eq({tag, "_flush_count"}, 32'(gf), 32'd0);
`endif
  endtask

  // Evaluate one cycle of the model at negedge, check, advance model, then move past posedge.
  task automatic run_cycle(input string tag);
    bit         lu;
    int         r;
    logic [7:0] e;
    lu = ex_memread && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (mh[k] || wb_halt)      begin r = 1; e = {7'b0000000, mh[k]}; end
      else if (dmem_stall)       begin r = 2; e = 8'b00000000; end
      else if (ex_branch_taken)  begin r = 3; e = 8'b11111110; end
      else if (left[k] > 0)      begin r = 4; e = 8'b00111010; end
      else if (lu)               begin r = 5; e = 8'b00111010; end
      else if (imem_stall)       begin r = 6; e = 8'b01111100; end
      else                       begin r = 7; e = 8'b11111000; end
      check_eq({tag, (k == 0) ? "_n1_ctl" : "_n3_ctl"}, 32'((k == 0) ? o1 : o3), 32'(e));
      check_stats(k, {tag, (k == 0) ? "_n1" : "_n3"});
      if (!e[7] && !mh[k] && sc[k] < 65535) sc[k]++;
      if (r == 3 && fc[k] < 65535) fc[k]++;
      case (r)
        1: mh[k] = 1'b1;
        2, 3: left[k] = 0;
        4: left[k]--;
        5: left[k] = nval[k] - 1;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    wb_halt = 1'b0;
  endtask

  // Mid-cycle asynchronous reset; outputs must revert before any clock edge.
  task automatic do_reset(input string tag);
    clear_inputs();
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      mh[k] = 1'b0; left[k] = 0; sc[k] = 0; fc[k] = 0;
      check_eq({tag, (k == 0) ? "_rst_n1" : "_rst_n3"}, 32'((k == 0) ? o1 : o3), 32'h f8);
      check_stats(k, {tag, "_rst"});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_load_use(input logic [3:0] rd);
    ex_memread = 1'b1; ex_rd = rd; id_rs = 4'd3; id_uses_rs = 1'b1;
  endtask

  initial begin
    int halt_age;
    do_reset("init");

    // Load-use on r3, then the hazard clears.
    set_load_use(4'd3);
    run_cycle("lu");
    clear_inputs();
    repeat (3) run_cycle("lu_after");

    // Destination r0 never stalls.
    set_load_use(4'd0);
    run_cycle("lu_r0");
    clear_inputs();
    run_cycle("lu_r0_after");

    // Single-cycle taken branch.
    ex_branch_taken = 1'b1;
    run_cycle("br");
    clear_inputs();
    run_cycle("br_after");

    // Data-memory wait with a branch held in EX, then the branch resolves.
    ex_branch_taken = 1'b1;
    dmem_stall = 1'b1;
    repeat (4) run_cycle("dmem");
    dmem_stall = 1'b0;
    run_cycle("dmem_br");
    clear_inputs();
    run_cycle("dmem_after");

    // Instruction stall alone, then together with a load-use.
    imem_stall = 1'b1;
    run_cycle("imem");
    set_load_use(4'd3);
    id_uses_rs = 1'b0; id_rt = 4'd3; id_uses_rt = 1'b1;
    run_cycle("imem_lu");
    clear_inputs();
    repeat (3) run_cycle("imem_lu_after");

    // Halt is sticky regardless of later stimulus.
    wb_halt = 1'b1;
    run_cycle("halt");
    wb_halt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dmem_stall = i[0];
      ex_branch_taken = ~i[0];
      run_cycle("halted");
    end
    do_reset("halt");
    run_cycle("post_halt");

    // Reset while the 3-bubble instance is mid load stall.
    set_load_use(4'd5);
    id_rs = 4'd5;
    run_cycle("lu_mid");
    do_reset("mid_stall");
    run_cycle("mid_stall_after");

    // Randomized traffic with occasional halts and resets.
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      id_rs           = 4'($urandom_range(0, 3));
      id_rt           = 4'($urandom_range(0, 3));
      ex_rd           = 4'($urandom_range(0, 3));
      id_uses_rs      = ($urandom_range(0, 1) == 1);
      id_uses_rt      = ($urandom_range(0, 1) == 1);
      ex_memread      = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      imem_stall      = ($urandom_range(0, 4) == 0);
      dmem_stall      = ($urandom_range(0, 5) == 0);
      wb_halt         = ($urandom_range(0, 149) == 0);
      run_cycle("rnd");
      if (mh[0]) halt_age++;
      if (halt_age > 8 || $urandom_range(0, 399) == 0) begin
        halt_age = 0;
        do_reset("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the enable inputs and bubble-injection (flush) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards, taken-branch redirects, instruction/data memory wait states, and the terminal halt.
- Sits directly upstream of every pipeline register. A flush forces that register's signals_in to zero, making it a bubble.

Parameters:
- REG_ADDR_W, 4, register-specifier width; register 0 is hardwired zero and never causes a hazard.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- STAT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_rs  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rt  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  REG_ADDR_W  EX instruction destination register.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- imem_stall  in  1  instruction memory not ready this cycle.
- dmem_stall  in  1  data memory not ready this cycle.
- wb_halt  in  1  HLT instruction in WB.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush  out  1 each  bubble injection into IF/ID and ID/EX.
- halted  out  1  CPU halted (sticky).
- stall_cycles  out  STAT_W  frozen/stalled cycle count (optional feature).
- flush_count  out  STAT_W  branch flush event count (optional feature).

Behaviour:
- Reset (rst=0, async): state=RUN, load counter=0, halted=0. Enable and flush outputs are combinational and take the RUN defaults: all enables=1, all flushes=0.
- States:
  - RUN: normal.
  - LOAD_STALL: multi-cycle load bubble.
  - MEM_WAIT: data memory freeze.
  - HALT: terminal.
- Outputs are combinational from the current state and inputs. State updates on the rising clk edge.
- load_use is true when all of the following hold: ex_memread=1, ex_rd!=0, and ((id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd)).
- Priority, evaluated each cycle (highest first):
  1. state==HALT or wb_halt: all enables=0, all flushes=0; next state=HALT. halted=1 from the cycle after wb_halt and stays 1 until reset.
  2. dmem_stall: all enables=0, all flushes=0; next state=MEM_WAIT. Return to RUN the first cycle dmem_stall=0. ex_branch_taken stays asserted because ID/EX is frozen, so the branch is handled after the wait.
  3. ex_branch_taken: all enables=1, ifid_flush=1, idex_flush=1; next state=RUN. Any pending LOAD_STALL is abandoned and the counter is cleared.
  4. state==LOAD_STALL: pc_en=0, ifid_en=0, idex_flush=1, other enables=1. Decrement the counter; at counter==0 go to RUN.
  5. load_use (in RUN): same outputs as rule 4. If LOAD_STALL_CYCLES>1, load the counter with LOAD_STALL_CYCLES-2 and enter LOAD_STALL; otherwise stay in RUN.
  6. imem_stall: pc_en=0, ifid_flush=1, other enables=1; next state=RUN.
  7. Otherwise: RUN defaults.
- Simultaneous imem_stall and load_use: load_use wins. The PC is held anyway and IF/ID is held, not flushed.
- Reset asserted mid-stall or mid-halt returns to RUN immediately. Outputs revert asynchronously.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - stall_cycles increments (saturating at all-ones) every cycle pc_en=0 while not in HALT.
  - flush_count increments (saturating) on each rule-3 cycle.
  - Both clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset with rst=0 mid-cycle -> all enables=1, flushes=0, halted=0 immediately; both counters=0.
- ex_memread=1, ex_rd=3, id_rs=3, id_uses_rs=1, LOAD_STALL_CYCLES=1 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle (ex_memread=0) RUN defaults. Repeat with ex_rd=0 -> no stall. Repeat with LOAD_STALL_CYCLES=3 -> three consecutive stall cycles.
- ex_branch_taken=1 for one cycle -> ifid_flush=idex_flush=1, all enables=1; flush_count 0->1 with HAZARD_STATS_EN.
- dmem_stall=1 for 4 cycles with ex_branch_taken=1 held -> all enables=0 and no flush for 4 cycles; branch flush occurs on cycle 5; stall_cycles=4.
- imem_stall and load_use together -> pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
- wb_halt=1 for one cycle, then dmem_stall and ex_branch_taken toggled -> halted=1 and all enables=0 indefinitely; rst pulse returns to RUN.
